// File: rtl/msm_sequential_controller_if.sv
// Curve types and the controller bus: job request, point/scalar memory,
// and the Reset/Done handshakes of the multiplier and point adder.
package elliptic_curve_structs;
  parameter int COORD_W = 16;
  parameter int SCALAR_WIDTH = 16;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } curve_point_t;

  parameter curve_point_t inf_point = '{x: '0, y: '0};
endpackage

interface msm_sequential_controller_if
  import elliptic_curve_structs::*;
#(
  parameter int N_MAX = 16,
  parameter int ADDR_W = $clog2(N_MAX)
);
  logic                    Start;
  logic [ADDR_W:0]         N;
  logic                    mem_rd_en;
  logic [ADDR_W-1:0]       mem_addr;
  curve_point_t            mem_point;
  logic [SCALAR_WIDTH-1:0] mem_scalar;
  logic                    Busy;
  logic                    Done;
  curve_point_t            R;

  logic                    mul_reset;
  curve_point_t            mul_point;
  logic [SCALAR_WIDTH-1:0] mul_scalar;
  logic                    mul_done;
  curve_point_t            mul_result;

  logic                    add_reset;
  curve_point_t            add_p;
  curve_point_t            add_q;
  logic                    add_done;
  curve_point_t            add_sum;

  modport master (
    input  Start, N, mem_point, mem_scalar,
    input  mul_done, mul_result, add_done, add_sum,
    output mem_rd_en, mem_addr, Busy, Done, R,
    output mul_reset, mul_point, mul_scalar,
    output add_reset, add_p, add_q
  );

  modport slave (
    output Start, N, mem_point, mem_scalar,
    output mul_done, mul_result, add_done, add_sum,
    input  mem_rd_en, mem_addr, Busy, Done, R,
    input  mul_reset, mul_point, mul_scalar,
    input  add_reset, add_p, add_q
  );
endinterface

// File: rtl/msm_sequential_controller.sv
// Sequential MSM front end: R = sum k_i * P_i, one term at a time.
// Define MSM_SKIP_ZERO_EN to skip terms whose scalar is zero.
module msm_sequential_controller
  import elliptic_curve_structs::*;
#(
  parameter int N_MAX = 16,
  parameter int ADDR_W = $clog2(N_MAX)
) (
  input logic clk,
  input logic Reset,
  msm_sequential_controller_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, FETCH, WAIT_RD, MUL_START, MUL_WAIT,
    ADD_START, ADD_WAIT, NEXT, FINISH
  } state_t;

  localparam logic [ADDR_W:0] NMAX_W = (ADDR_W+1)'(N_MAX);

  state_t state, state_nx;
  logic [ADDR_W:0] i_q, n_q, n_clamp, i_inc;
  curve_point_t p_q, t_q, acc_q, r_q;
  logic [SCALAR_WIDTH-1:0] k_q;
  logic acc_inf, busy_q, done_q;
  logic skip_term;

  assign n_clamp = (bus.N > NMAX_W) ? NMAX_W : bus.N;
  assign i_inc = i_q + (ADDR_W+1)'(1);

`ifdef MSM_SKIP_ZERO_EN
  assign skip_term = (bus.mem_scalar == '0);
`else
  assign skip_term = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (bus.Start)
          state_nx = (n_clamp == '0) ? FINISH : FETCH;
      FETCH:     state_nx = WAIT_RD;
      WAIT_RD:   state_nx = skip_term ? NEXT : MUL_START;
      MUL_START: state_nx = MUL_WAIT;
      MUL_WAIT:
        if (bus.mul_done)
          state_nx = acc_inf ? NEXT : ADD_START;
      ADD_START: state_nx = ADD_WAIT;
      ADD_WAIT:
        if (bus.add_done) state_nx = NEXT;
      NEXT:
        state_nx = (i_inc == n_q) ? FINISH : FETCH;
      FINISH:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // The first product is loaded straight into acc; it is never added to infinity.
  always_ff @(posedge clk) begin
    if (Reset) begin
      i_q     <= '0;
      n_q     <= '0;
      p_q     <= inf_point;
      k_q     <= '0;
      t_q     <= inf_point;
      acc_q   <= inf_point;
      acc_inf <= 1'b1;
      r_q     <= inf_point;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (bus.Start) begin
            n_q     <= n_clamp;
            i_q     <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            acc_q   <= inf_point;
            acc_inf <= 1'b1;
          end
        WAIT_RD: begin
          p_q <= bus.mem_point;
          k_q <= bus.mem_scalar;
        end
        MUL_WAIT:
          if (bus.mul_done) begin
            t_q <= bus.mul_result;
            if (acc_inf) begin
              acc_q   <= bus.mul_result;
              acc_inf <= 1'b0;
            end
          end
        ADD_WAIT:
          if (bus.add_done) acc_q <= bus.add_sum;
        NEXT: i_q <= i_inc;
        FINISH: begin
          r_q    <= acc_q;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_rd_en  = (state == FETCH);
  assign bus.mem_addr   = i_q[ADDR_W-1:0];
  assign bus.mul_reset  = Reset | (state == MUL_START);
  assign bus.add_reset  = Reset | (state == ADD_START);
  assign bus.mul_point  = p_q;
  assign bus.mul_scalar = k_q;
  assign bus.add_p      = acc_q;
  assign bus.add_q      = t_q;
  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;
  assign bus.R          = r_q;
endmodule

// File: tb/tb_msm_sequential_controller.sv
// Bench for msm_sequential_controller: behavioural memory, multiplier and
// adder over a toy additive group; results against a direct weighted sum.
module tb_msm_sequential_controller;
  import elliptic_curve_structs::*;

  localparam int N_MAX = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  msm_sequential_controller_if #(.N_MAX(N_MAX), .ADDR_W(ADDR_W)) bus ();

  msm_sequential_controller #(.N_MAX(N_MAX), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .Reset(Reset),
    .bus(bus)
  );

  curve_point_t mem_p [N_MAX];
  logic [SCALAR_WIDTH-1:0] mem_k [N_MAX];
  int mul_pulses = 0;
  int add_pulses = 0;
  int rd_count = 0;
  int mul_cnt = 0;
  int add_cnt = 0;
  int addr_log [$];
  int checks = 0;
  int errors = 0;

  function automatic curve_point_t smul(curve_point_t p, logic [15:0] k);
    curve_point_t r;
    r.x = p.x * k;
    r.y = p.y * k;
    return r;
  endfunction

  function automatic curve_point_t padd(curve_point_t a, curve_point_t b);
    curve_point_t r;
    r.x = a.x + b.x;
    r.y = a.y + b.y;
    return r;
  endfunction

  // Reference: sum of k_j * P_j over the clamped term count, plain integers.
  function automatic curve_point_t ref_msm(input int n);
    longint sx, sy;
    curve_point_t r;
    int m;
    sx = 0;
    sy = 0;
    m = (n > N_MAX) ? N_MAX : n;
    for (int j = 0; j < m; j++) begin
      sx += longint'(mem_k[j]) * longint'(mem_p[j].x);
      sy += longint'(mem_k[j]) * longint'(mem_p[j].y);
    end
    r.x = sx[15:0];
    r.y = sy[15:0];
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd_en === 1'b1) begin
      bus.mem_point  <= mem_p[bus.mem_addr];
      bus.mem_scalar <= mem_k[bus.mem_addr];
      rd_count <= rd_count + 1;
      addr_log.push_back(int'(bus.mem_addr));
    end
  end

  always @(posedge clk) begin
    if (bus.mul_reset === 1'b1) begin
      bus.mul_done <= 1'b0;
      mul_cnt <= int'($urandom_range(4, 1));
      if (Reset !== 1'b1) mul_pulses <= mul_pulses + 1;
    end else if (mul_cnt > 0) begin
      mul_cnt <= mul_cnt - 1;
      if (mul_cnt == 1) begin
        bus.mul_done   <= 1'b1;
        bus.mul_result <= smul(bus.mul_point, bus.mul_scalar);
      end
    end
  end

  always @(posedge clk) begin
    if (bus.add_reset === 1'b1) begin
      bus.add_done <= 1'b0;
      add_cnt <= int'($urandom_range(4, 1));
      if (Reset !== 1'b1) add_pulses <= add_pulses + 1;
    end else if (add_cnt > 0) begin
      add_cnt <= add_cnt - 1;
      if (add_cnt == 1) begin
        bus.add_done <= 1'b1;
        bus.add_sum  <= padd(bus.add_p, bus.add_q);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input string tag, input int n, input bit poke,
                         output int lat);
    int m0, a0, r0, q0, cyc, neff, mults, adds;
    bit busy_ok, addr_ok;
    curve_point_t exp_r;
    neff = (n > N_MAX) ? N_MAX : n;
    exp_r = ref_msm(n);
    mults = 0;
    for (int j = 0; j < neff; j++) begin
`ifdef MSM_SKIP_ZERO_EN
      if (mem_k[j] != '0) mults++;
`else
      mults++;
`endif
    end
    adds = (mults > 0) ? mults - 1 : 0;
    m0 = mul_pulses;
    a0 = add_pulses;
    r0 = rd_count;
    q0 = addr_log.size();
    bus.Start = 1'b1;
    bus.N = 5'(n);
    @(negedge clk);
    bus.Start = 1'b0;
    check({tag, "_start"}, 64'({bus.Busy, bus.Done}), 64'(2'b10));
    cyc = 1;
    busy_ok = 1'b1;
    while (bus.Done !== 1'b1 && cyc < 2000) begin
      if (bus.Busy !== 1'b1) busy_ok = 1'b0;
      bus.Start = poke && (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    bus.Start = 1'b0;
    lat = cyc;
    check({tag, "_done"}, 64'(bus.Done), 64'(1));
    check({tag, "_busy_held"}, 64'(busy_ok), 64'(1));
    check({tag, "_busy_low"}, 64'(bus.Busy), 64'(0));
    check({tag, "_r"}, 64'(bus.R), 64'(exp_r));
    check({tag, "_mul_pulses"}, 64'(mul_pulses - m0), 64'(mults));
    check({tag, "_add_pulses"}, 64'(add_pulses - a0), 64'(adds));
    check({tag, "_reads"}, 64'(rd_count - r0), 64'(neff));
    addr_ok = (addr_log.size() - q0 == neff);
    for (int j = 0; j < neff && addr_ok; j++)
      if (addr_log[q0 + j] != j) addr_ok = 1'b0;
    check({tag, "_addr_seq"}, 64'(addr_ok), 64'(1));
  endtask

  task automatic load_random(input int n);
    for (int j = 0; j < N_MAX; j++) begin
      mem_p[j].x = 16'($urandom);
      mem_p[j].y = 16'($urandom);
      mem_k[j] = ($urandom_range(3, 0) == 0) ? 16'h0 : 16'($urandom);
    end
    if (n > 0) mem_k[0] = mem_k[0];
  endtask

  initial begin
    curve_point_t g, g2, exp_r;
    int lat, cyc;
    g = '{x: 16'h1234, y: 16'h0abc};
    g2 = smul(g, 16'd2);
    Reset = 1'b1;
    bus.Start = 1'b0;
    bus.N = '0;
    load_random(N_MAX);
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.Busy), 64'(0));
    check("rst_done", 64'(bus.Done), 64'(0));
    check("rst_rd_en", 64'(bus.mem_rd_en), 64'(0));
    check("rst_addr", 64'(bus.mem_addr), 64'(0));
    check("rst_r", 64'(bus.R), 64'(inf_point));
    check("rst_sub_resets", 64'({bus.mul_reset, bus.add_reset}), 64'(2'b11));
    Reset = 1'b0;
    @(negedge clk);
    check("idle_sub_resets", 64'({bus.mul_reset, bus.add_reset}), 64'(2'b00));

    mem_p[0] = g; mem_k[0] = 16'd1;
    run_job("n1_g", 1, 1'b0, lat);
    check("n1_r_is_g", 64'(bus.R), 64'(g));

    mem_p[0] = g; mem_p[1] = g; mem_k[0] = 16'd2; mem_k[1] = 16'd3;
    run_job("n2_5g", 2, 1'b0, lat);
    check("n2_r_is_5g", 64'(bus.R), 64'(smul(g, 16'd5)));

    mem_p[0] = g; mem_p[1] = g2; mem_p[2] = g;
    mem_k[0] = 16'd1; mem_k[1] = 16'd1; mem_k[2] = 16'd4;
    run_job("n3_7g_poke", 3, 1'b1, lat);
    check("n3_r_is_7g", 64'(bus.R), 64'(smul(g, 16'd7)));

    run_job("n0", 0, 1'b0, lat);
    check("n0_latency", 64'(lat), 64'(2));

    mem_p[0] = g; mem_p[1] = g; mem_k[0] = 16'd0; mem_k[1] = 16'd5;
    run_job("k0_5g", 2, 1'b0, lat);
    exp_r = smul(g, 16'd5);
    repeat (3) @(negedge clk);
    check("hold_done", 64'(bus.Done), 64'(1));
    check("hold_r", 64'(bus.R), 64'(exp_r));

    load_random(N_MAX);
    run_job("clamp_n20", 20, 1'b0, lat);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = int'($urandom_range(N_MAX, 1));
      load_random(n);
      run_job($sformatf("rand%0d", t), n, t[0], lat);
    end

    load_random(3);
    mem_k[0] = 16'd7; mem_k[1] = 16'd9;
    begin
      int m0;
      m0 = mul_pulses;
      bus.Start = 1'b1;
      bus.N = 5'd3;
      @(negedge clk);
      bus.Start = 1'b0;
      cyc = 0;
      while (mul_pulses - m0 < 2 && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      check("abort_reached_term1", 64'(mul_pulses - m0), 64'(2));
      check("abort_mul_wait", 64'(bus.mul_reset), 64'(0));
    end
    Reset = 1'b1;
    #1;
    check("abort_sub_resets", 64'({bus.mul_reset, bus.add_reset}), 64'(2'b11));
    @(negedge clk);
    Reset = 1'b0;
    check("abort_busy", 64'(bus.Busy), 64'(0));
    check("abort_done", 64'(bus.Done), 64'(0));
    check("abort_r", 64'(bus.R), 64'(inf_point));

    Reset = 1'b1;
    bus.Start = 1'b1;
    bus.N = 5'd1;
    @(negedge clk);
    Reset = 1'b0;
    bus.Start = 1'b0;
    @(negedge clk);
    check("start_with_reset_ignored", 64'(bus.Busy), 64'(0));

    mem_k[0] = 16'd1;
    run_job("after_abort", 1, 1'b0, lat);
    check("after_abort_r_p0", 64'(bus.R), 64'(mem_p[0]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
